// File: rtl/avr_cmd_pkg.sv
// Shared command codes, op encoding and FSM state type for the avr_ctrl issuer.
package avr_cmd_pkg;

   localparam int unsigned CODE_W = 7;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned ARG_W  = 32;

   typedef logic [CODE_W-1:0] code_t;

   localparam code_t C_IDLE         = 7'h01;
   localparam code_t C_RESET_LO     = 7'h02;
   localparam code_t C_RESET_HI     = 7'h03;
   localparam code_t C_SREG_EN_LO   = 7'h04;
   localparam code_t C_SREG_EN_HI   = 7'h05;
   localparam code_t C_SI_LO        = 7'h06;
   localparam code_t C_SI_HI        = 7'h07;
   localparam code_t C_OE_LO        = 7'h08;
   localparam code_t C_OE_HI        = 7'h09;
   localparam code_t C_WE_LO        = 7'h0A;
   localparam code_t C_WE_HI        = 7'h0C;
   localparam code_t C_COUNTER_LO   = 7'h0D;
   localparam code_t C_COUNTER_HI   = 7'h0E;
   localparam code_t C_SNES_MODE_LO = 7'h0F;
   localparam code_t C_SNES_MODE_HI = 7'h10;

   typedef enum logic [OP_W-1:0] {
      OP_NOP          = 3'd0,
      OP_RESET_PULSE  = 3'd1,
      OP_LOAD_ADDR    = 3'd2,
      OP_WRITE_STROBE = 3'd3,
      OP_READ_STROBE  = 3'd4,
      OP_INC_ADDR     = 3'd5,
      OP_SET_MODE     = 3'd6,
      OP_RSVD         = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1,
      S_DONE = 2'd2
   } state_e;

   typedef struct packed {
      op_e              op;
      logic [ARG_W-1:0] arg;
   } cmd_t;

   function automatic code_t si_code(input logic b);
      return b ? C_SI_HI : C_SI_LO;
   endfunction

endpackage

// File: rtl/avr_cmd_hold_timer.sv
// Loadable down-counter timing how long each command code stays on the bus.
module avr_cmd_hold_timer #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire_c
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign expire_c = (count == '0);

endmodule

// File: rtl/avr_command_sequencer.sv
// Expands high-level cartridge operations into timed avr_ctrl command code sequences.
module avr_command_sequencer
   import avr_cmd_pkg::*;
#(
   parameter int unsigned HOLD      = 2,
   parameter int unsigned ADDR_BITS = 24,
   parameter int unsigned READ_WAIT = 4
) (
   input  logic                avr_clk,
   input  logic                avr_rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [OP_W-1:0]     cmd_op,
   input  logic [ARG_W-1:0]    cmd_arg,
   output logic [CODE_W-1:0]   avr_ctrl,
   output logic                busy,
   output logic                done
);

   localparam int unsigned TW    = $clog2(HOLD + READ_WAIT + 1);
   localparam int unsigned IDX_W = (ADDR_BITS > 1) ? $clog2(ADDR_BITS) : 1;
   localparam logic [TW-1:0]    HOLD_LD = TW'(HOLD - 1);
   localparam logic [TW-1:0]    READ_LD = TW'(HOLD + READ_WAIT - 1);
   localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(ADDR_BITS - 1);

   state_e           state;
   cmd_t             cmd_q;
   logic [IDX_W-1:0] bit_idx;

   logic    accept_c;
   logic    first_none_c;
   code_t   first_code_c;
   code_t   nxt_code_c;
   logic    last_c;
   code_t   load_code_c;
   logic    tmr_load_c;
   logic [TW-1:0] tmr_val_c;
   logic    expire_c;

   assign accept_c = cmd_valid & cmd_ready;

   // First code of a newly requested op; ops without codes go straight to S_DONE.
   always_comb begin
      first_code_c = C_IDLE;
      first_none_c = 1'b0;
      case (op_e'(cmd_op))
         OP_RESET_PULSE:  first_code_c = C_RESET_HI;
         OP_LOAD_ADDR:    first_code_c = C_SREG_EN_LO;
         OP_WRITE_STROBE: first_code_c = C_WE_LO;
         OP_READ_STROBE:  first_code_c = C_OE_LO;
         OP_INC_ADDR:     first_code_c = C_COUNTER_LO;
         OP_SET_MODE:     first_code_c = cmd_arg[0] ? C_SNES_MODE_HI : C_SNES_MODE_LO;
         default:         first_none_c = 1'b1;
      endcase
   end

   // Successor of the code on the bus; every successor differs from its predecessor.
   always_comb begin
      nxt_code_c = C_IDLE;
      last_c     = 1'b0;
      case (avr_ctrl)
         C_RESET_HI:       nxt_code_c = C_RESET_LO;
         C_WE_LO:          nxt_code_c = C_WE_HI;
         C_OE_LO:          nxt_code_c = C_OE_HI;
         C_COUNTER_LO:     nxt_code_c = C_COUNTER_HI;
         C_SREG_EN_LO:     nxt_code_c = si_code(cmd_q.arg[TOP_IDX]);
         C_SI_LO, C_SI_HI: nxt_code_c = C_COUNTER_LO;
         C_COUNTER_HI: begin
            if (cmd_q.op == OP_LOAD_ADDR) begin
               nxt_code_c = (bit_idx == '0) ? C_SREG_EN_HI
                                            : si_code(cmd_q.arg[bit_idx - IDX_W'(1)]);
            end else begin
               last_c = 1'b1;
            end
         end
         default:          last_c = 1'b1;
      endcase
   end

   assign load_code_c = (state == S_IDLE) ? first_code_c : nxt_code_c;
   assign tmr_load_c  = (state == S_IDLE) ? (accept_c & ~first_none_c)
                                          : ((state == S_EMIT) & expire_c & ~last_c);
   assign tmr_val_c   = (load_code_c == C_OE_LO) ? READ_LD : HOLD_LD;

   avr_cmd_hold_timer #(.W(TW)) u_hold_timer (
      .clk      (avr_clk),
      .rst      (avr_rst),
      .load     (tmr_load_c),
      .load_val (tmr_val_c),
      .expire_c (expire_c)
   );

   always_ff @(posedge avr_clk or posedge avr_rst) begin
      if (avr_rst) begin
         state     <= S_IDLE;
         cmd_q     <= '{op: OP_NOP, arg: '0};
         bit_idx   <= '0;
         avr_ctrl  <= C_IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept_c) begin
                  cmd_q     <= '{op: op_e'(cmd_op), arg: cmd_arg};
                  bit_idx   <= TOP_IDX;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (first_none_c) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= S_EMIT;
                     avr_ctrl <= first_code_c;
                  end
               end
            end
            S_EMIT: begin
               if (expire_c) begin
                  if (last_c) begin
                     state    <= S_DONE;
                     avr_ctrl <= C_IDLE;
                     done     <= 1'b1;
                  end else begin
                     avr_ctrl <= nxt_code_c;
                     if (avr_ctrl == C_COUNTER_HI && bit_idx != '0) begin
                        bit_idx <= bit_idx - IDX_W'(1);
                     end
                  end
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
